// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types and width helpers for the programmable sequence detector
// Optional match counters are enabled by PROG_SEQ_MATCH_CNT_EN.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    HUNT     = 2'd2
  } slot_state_e;

  localparam int MASK_W = 64;

  function automatic int LEN_W(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int IDX_W(input int num_pat);
    return (num_pat > 1) ? $clog2(num_pat) : 1;
  endfunction

  function automatic logic [MASK_W-1:0] pat_mask(input int len);
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/prog_seq_slot.sv
// rtl/prog_seq_slot.sv - one pattern slot: stored pattern, fill/hunt FSM and registered match pulse
// PROG_SEQ_MATCH_CNT_EN adds a saturating per-slot match counter.
module prog_seq_slot
  import prog_seq_pkg::*;
#(
  parameter int MAX_LEN = 8
`ifdef PROG_SEQ_MATCH_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [MAX_LEN-1:0]        wr_pattern,
  input  logic [LEN_W(MAX_LEN)-1:0] wr_len,
  input  logic                      wr_overlap,
  input  logic                      din_valid,
  input  logic [MAX_LEN-1:0]        hist_next,
  output logic                      seen_next,
  output logic                      seen
`ifdef PROG_SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]          match_cnt
`endif
);

  localparam int LW = LEN_W(MAX_LEN);

  slot_state_e        state_q, state_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic               seen_q, seen_d;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  assign mask  = MAX_LEN'(pat_mask(int'(len_q)));
  assign match = ((hist_next ^ pat_q) & mask) == '0;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    len_d   = len_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    seen_d  = 1'b0;
    // A write always wins: the bit sampled alongside it must not count for this slot.
    if (wr_en) begin
      pat_d   = wr_pattern;
      len_d   = wr_len;
      ovl_d   = wr_overlap;
      fill_d  = '0;
      state_d = (wr_len == '0) ? DISABLED : FILL;
    end else if (din_valid) begin
      case (state_q)
        FILL: begin
          if (fill_q == len_q - LW'(1)) begin
            if (match) begin
              seen_d  = 1'b1;
              state_d = ovl_q ? HUNT : FILL;
              fill_d  = '0;
            end else begin
              state_d = HUNT;
            end
          end else begin
            fill_d = fill_q + LW'(1);
          end
        end
        HUNT: begin
          if (match) begin
            seen_d = 1'b1;
            if (!ovl_q) begin
              state_d = FILL;
              fill_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= DISABLED;
      fill_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      seen_q  <= seen_d;
    end
  end

  assign seen_next = seen_d;
  assign seen      = seen_q;

`ifdef PROG_SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q <= '0;
    end else if (wr_en) begin
      cnt_q <= '0;
    end else if (seen_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: rtl/prog_seq_detector_multi.sv
// rtl/prog_seq_detector_multi.sv - shared history, config decode and NUM_PAT pattern slots
// PROG_SEQ_MATCH_CNT_EN exposes per-slot saturating match counters on match_cnt.
module prog_seq_detector_multi
  import prog_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2
`ifdef PROG_SEQ_MATCH_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cfg_we,
  input  logic [IDX_W(NUM_PAT)-1:0] cfg_idx,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [LEN_W(MAX_LEN)-1:0] cfg_len,
  input  logic                      cfg_overlap,
  output logic                      cfg_err,
  input  logic                      din_valid,
  input  logic                      din,
  output logic [NUM_PAT-1:0]        seen,
  output logic                      seen_any
`ifdef PROG_SEQ_MATCH_CNT_EN
  ,
  output logic [NUM_PAT*CNT_W-1:0]  match_cnt
`endif
);

  localparam int IW = IDX_W(NUM_PAT);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic               err_q, err_d;
  logic               any_q, any_d;
  logic               cfg_legal;
  logic [NUM_PAT-1:0] seen_next;

  assign hist_d    = din_valid ? {hist_q[MAX_LEN-2:0], din} : hist_q;
  // Compare as int so an idx width that cannot represent NUM_PAT still decodes correctly.
  assign cfg_legal = cfg_we && (int'(cfg_len) <= MAX_LEN) && (int'(cfg_idx) < NUM_PAT);
  assign err_d     = cfg_we && !cfg_legal;
  assign any_d     = |seen_next;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      hist_q <= '0;
      err_q  <= 1'b0;
      any_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      err_q  <= err_d;
      any_q  <= any_d;
    end
  end

  assign cfg_err  = err_q;
  assign seen_any = any_q;

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
    prog_seq_slot #(
      .MAX_LEN    (MAX_LEN)
`ifdef PROG_SEQ_MATCH_CNT_EN
      ,
      .CNT_W      (CNT_W)
`endif
    ) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .wr_en      (cfg_legal && (cfg_idx == IW'(i))),
      .wr_pattern (cfg_pattern),
      .wr_len     (cfg_len),
      .wr_overlap (cfg_overlap),
      .din_valid  (din_valid),
      .hist_next  (hist_d),
      .seen_next  (seen_next[i]),
      .seen       (seen[i])
`ifdef PROG_SEQ_MATCH_CNT_EN
      ,
      .match_cnt  (match_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: doc/prog_seq_detector_multi.md
Name: prog_seq_detector_multi

Overview:
- Parametrised, multi-pattern programmable serial sequence detector.
- Shifts one qualified bit per cycle into a shared history register and compares it against NUM_PAT independently programmed patterns.
- Each pattern has its own length and overlap mode.
- Sits on serial data paths: framing/sync-word search, and control-sequence detection for downstream FSMs.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; history register width.
- NUM_PAT, 2: number of independent pattern slots.
- CNT_W, 8: per-slot match counter width (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous reset, active-high (asserted = 1); name kept for codebase consistency.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  max(1,$clog2(NUM_PAT))  slot written.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] oldest, bit 0 newest.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; 0 disables the slot.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse on an illegal write.
- din_valid  in  1  qualifies din.
- din  in  1  serial data bit.
- seen  out  NUM_PAT  per-slot match pulse.
- seen_any  out  1  OR of seen.

Behaviour:
Reset:
- While resetn = 1: history, all slot registers, fill counters, seen, seen_any, cfg_err and counters are 0.
- All slots disabled (len = 0).
- Takes effect immediately, mid-sequence included. Partial matches are discarded.

History:
- On clk, when din_valid = 1: hist <= {hist[MAX_LEN-2:0], din}.
- When din_valid = 0: history holds.

Per-slot state machine:
- DISABLED: len = 0. Leaves on a legal write with len > 0 → FILL, fill = 0.
- FILL: fill < len. Each valid bit increments fill. When fill reaches len-1 and a valid bit arrives, the slot compares and enters HUNT.
- HUNT: compares on every valid bit.
- A legal write to a slot from any state → FILL with fill = 0, so only bits arriving after the write can contribute to a match.
- A write with len = 0 → DISABLED.

Match:
- The next-history value {hist, din}[len-1:0] equals pattern[len-1:0], evaluated on the same edge that samples the final bit.
- Bits above len are ignored.
- seen[i] is registered: high for exactly the cycle after the completing edge, then low unless another match occurs.
- No match is possible on a cycle where din_valid = 0.

Overlap modes:
- overlap = 1: stays in HUNT after a match. Example: 101 in bits 10101 matches twice.
- overlap = 0: after a match the slot returns to FILL with fill = 0 and needs len fresh bits. Example: 10101 matches once.

Configuration:
- Write is accepted when cfg_we = 1 and cfg_len <= MAX_LEN and cfg_idx < NUM_PAT.
- Any other write is ignored, and cfg_err pulses 1 the following cycle.
- If cfg_we and din_valid are high in the same cycle: the bit still enters the history, and the written slot restarts at fill = 0 (the bit does not count for that slot). Other slots are unaffected.

Other:
- seen_any is registered: the OR of next-seen, so it has the same timing as seen.
- len = MAX_LEN uses the full history. len = 1 matches on every valid bit equal to pattern[0].

Optional Feature:
- Macro: PROG_SEQ_MATCH_CNT_EN.
- With the macro defined:
  - Adds output match_cnt, NUM_PAT*CNT_W bits wide, slot i at [i*CNT_W +: CNT_W].
  - Each counter increments on every seen pulse and saturates at all-ones.
  - A counter clears on reset and on any legal write to its slot.
- Without the macro: the port and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package prog_seq_pkg:
  - slot state enum (DISABLED, FILL, HUNT).
  - LEN_W and IDX_W width-calculation functions.
  - Pattern mask helper: returns (1<<len)-1.
- Sub-module prog_seq_slot:
  - One instance per slot, generated NUM_PAT times.
  - Holds pattern, len, overlap, fill counter, FSM, seen register and the optional counter.
  - Takes the shared history, din and din_valid as inputs.
- Top level holds the history register, config decode, cfg_err and seen_any.

Test Plan:
1. Reset mid-stream: program slot0 = 3'b101 len 3, send 1,0, assert resetn for 1 cycle, send 1 → seen stays 0 throughout; slot0 is DISABLED after reset.
2. Overlap on: slot0 = 101, len 3, overlap 1; send 1,0,1,0,1 with din_valid = 1 → seen[0] pulses the cycles after bits 3 and 5.
3. Overlap off, same pattern and stream → single pulse after bit 3; bit 5 gives no pulse.
4. Gapped valid: slot1 = 4'b1100 len 4; send 1,1,(din_valid = 0 for 3 cycles),0,0 → one pulse after the last 0; seen_any equals seen[1].
5. Config edge cases: write cfg_len = 9 with MAX_LEN = 8 → cfg_err pulse, slot unchanged. Write slot0 in the same cycle as the final bit of a would-be match → no pulse. Re-send the full pattern → pulse.
6. With PROG_SEQ_MATCH_CNT_EN, CNT_W = 2: slot0 len 1 pattern 1; send five 1s → match_cnt slot0 reads 1,2,3,3,3 (saturates); a rewrite clears it to 0.
